// File: rtl/frequency_monitor_scanner_pkg.sv
// Shared types and constants for the frequency monitor scanner.
package frequency_monitor_scanner_pkg;

    localparam int FREQ_WIDTH    = 30;
    localparam int STAT_VALID    = 31;
    localparam int STAT_USED_INT = 30;
    localparam int STAT_FREQ_MSB = 29;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_SELECT  = 3'd2,
        S_SETTLE  = 3'd3,
        S_CAPTURE = 3'd4
    } scan_state_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int sel_width(input int nf);
        return (nf == 1) ? 1 : $clog2(nf);
    endfunction

endpackage

// File: rtl/frequency_monitor_scanner_if.sv
// Counter readout and CPU CSR signals seen by the scanner.
// Handshake: there is no valid/ready pair on this bus. selStrobe and csrStrobe
// are single-cycle write strobes; the receiver must accept the data presented
// with the strobe on that same edge. counterStatus and status are plain levels.
interface frequency_monitor_scanner_if;
    logic        selStrobe;
    logic [31:0] selValue;
    logic [31:0] counterStatus;
    logic        csrStrobe;
    logic [31:0] GPIO_OUT;
    logic [31:0] status;

    modport master (
        output selStrobe, selValue, status,
        input  counterStatus, csrStrobe, GPIO_OUT
    );

    modport slave (
        input  selStrobe, selValue, status,
        output counterStatus, csrStrobe, GPIO_OUT
    );
endinterface

// File: rtl/frequency_monitor_scanner_limit_check.sv
// Per-channel range check with a sticky alarm bit.
module frequency_limit_check
    import frequency_monitor_scanner_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap_en_i,
    input  logic                  clr_i,
    input  logic [FREQ_WIDTH-1:0] freq_i,
    input  logic [FREQ_WIDTH-1:0] low_i,
    input  logic [FREQ_WIDTH-1:0] high_i,
    output logic                  alarm_o
);

    logic alarm_q, alarm_d;
    logic out_of_range;

    // A zero upper bound disables checking for this channel.
    assign out_of_range = (high_i != '0) && ((freq_i < low_i) || (freq_i > high_i));

    // Clear first, then a failing capture overrides it in the same cycle.
    always_comb begin
        alarm_d = alarm_q;
        if (clr_i)
            alarm_d = 1'b0;
        if (cap_en_i && out_of_range)
            alarm_d = 1'b1;
    end

    // Alarm register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alarm_q <= 1'b0;
        else
            alarm_q <= alarm_d;
    end

    assign alarm_o = alarm_q;

endmodule

// File: rtl/frequency_monitor_scanner.sv
// Scans all counter channels after each acquisition marker, banks the results
// and exposes one selected channel through a registered CSR status word.
module frequency_monitor_scanner
    import frequency_monitor_scanner_pkg::*;
#(
    parameter int NF     = 2,
    parameter int DELAY  = 16,
    parameter int SETTLE = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ppsStrobe,
    frequency_monitor_scanner_if.master bus,
    input  logic [NF*FREQ_WIDTH-1:0]   lowLimit,
    input  logic [NF*FREQ_WIDTH-1:0]   highLimit,
    output logic [NF-1:0]              alarm,
    output logic                       busy,
    output scan_state_t                dbg_state_o
);

    localparam int SW    = sel_width(NF);
    localparam int CNT_W = $clog2(((DELAY > SETTLE) ? DELAY : SETTLE) + 1);
    localparam logic [SW-1:0]    LAST_CH   = SW'(NF - 1);
    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    ch_q, ch_d;
    logic             pend_q, pend_d;
    logic [SW-1:0]    rb_q, rb_d;
    logic [31:0]      status_q, status_d;
    logic             cap_en;
    logic             clr_alarm;

    logic [FREQ_WIDTH-1:0] freq_q [NF];
    logic [NF-1:0]         used_q;
    logic [NF-1:0]         valid_q;

    assign clr_alarm = bus.csrStrobe & bus.GPIO_OUT[31];

    // Scan sequencer: next state, counters, channel and pending-marker logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        pend_d  = pend_q;
        cap_en  = 1'b0;
        if (state_q != S_IDLE && ppsStrobe)
            pend_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (ppsStrobe) begin
                    state_d = S_WAIT;
                    cnt_d   = DELAY_LD;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_SELECT;
                    ch_d    = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SELECT: begin
                state_d = S_SETTLE;
                cnt_d   = SETTLE_LD;
            end
            S_SETTLE: begin
                if (cnt_q == '0)
                    state_d = S_CAPTURE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            S_CAPTURE: begin
                cap_en = 1'b1;
                if (ch_q == LAST_CH) begin
                    // A marker seen during this scan (or right now) restarts it once.
                    pend_d = 1'b0;
                    if (pend_q || ppsStrobe) begin
                        state_d = S_WAIT;
                        cnt_d   = DELAY_LD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_SELECT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
        end
    end

    // Measurement bank, written only in the capture cycle of the current channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NF; i++)
                freq_q[i] <= '0;
            used_q  <= '0;
            valid_q <= '0;
        end else if (cap_en) begin
            freq_q[ch_q]  <= bus.counterStatus[STAT_FREQ_MSB:0];
            used_q[ch_q]  <= bus.counterStatus[31];
            valid_q[ch_q] <= 1'b1;
        end
    end

    // Readback channel select from the CPU and the status word it picks.
    always_comb begin
        rb_d     = rb_q;
        status_d = '0;
        if (bus.csrStrobe)
            rb_d = bus.GPIO_OUT[SW-1:0];
        if (int'(rb_q) < NF) begin
            status_d[STAT_VALID]          = valid_q[rb_q];
            status_d[STAT_USED_INT]       = used_q[rb_q];
            status_d[STAT_FREQ_MSB:0]     = freq_q[rb_q];
        end
    end

    // Readback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_q     <= '0;
            status_q <= '0;
        end else begin
            rb_q     <= rb_d;
            status_q <= status_d;
        end
    end

    for (genvar n = 0; n < NF; n++) begin : g_chk
        frequency_limit_check u_chk (
            .clk      (clk),
            .rst_n    (rst_n),
            .cap_en_i (cap_en && (ch_q == SW'(n))),
            .clr_i    (clr_alarm),
            .freq_i   (bus.counterStatus[STAT_FREQ_MSB:0]),
            .low_i    (lowLimit[n*FREQ_WIDTH +: FREQ_WIDTH]),
            .high_i   (highLimit[n*FREQ_WIDTH +: FREQ_WIDTH]),
            .alarm_o  (alarm[n])
        );
    end

    assign bus.selStrobe = (state_q == S_SELECT);
    assign bus.selValue  = 32'(ch_q);
    assign bus.status    = status_q;
    assign busy          = (state_q != S_IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_frequency_monitor_scanner.sv
// Directed bench for frequency_monitor_scanner with a small counter model.
module tb_frequency_monitor_scanner;
  import frequency_monitor_scanner_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ppsStrobe = 1'b0;
  logic [59:0] lowLimit;
  logic [59:0] highLimit;
  logic [1:0]  alarm;
  logic        busy;
  scan_state_t dbg_state;

  frequency_monitor_scanner_if bus();

  frequency_monitor_scanner #(.NF(2), .DELAY(16), .SETTLE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ppsStrobe   (ppsStrobe),
    .bus         (bus),
    .lowLimit    (lowLimit),
    .highLimit   (highLimit),
    .alarm       (alarm),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pps_cyc = 0;
  int busy_cnt = 0;
  int sel_log[$];
  int selv_log[$];
  logic [31:0] ch_val0 = 32'h05F5E100;
  logic [31:0] ch_val1 = 32'h87735940;
  logic sel_lat = 1'b0;

  // counter model: select latched on selStrobe, status follows the selection
  assign bus.counterStatus = sel_lat ? ch_val1 : ch_val0;
  always @(posedge clk) if (bus.selStrobe) sel_lat <= bus.selValue[0];

  // edge monitor: values seen here are the ones present just before the edge
  always @(posedge clk) begin
    cyc++;
    if (ppsStrobe) pps_cyc = cyc;
    if (bus.selStrobe) begin
      sel_log.push_back(cyc);
      selv_log.push_back(int'(bus.selValue));
    end
    if (busy) busy_cnt++;
  end

  task clear_logs();
    sel_log.delete();
    selv_log.delete();
    busy_cnt = 0;
  endtask

  task pulse_pps();
    @(negedge clk) ppsStrobe = 1'b1;
    @(negedge clk) ppsStrobe = 1'b0;
  endtask

  task pps_at(input int target);
    while (cyc < target - 1) @(negedge clk);
    ppsStrobe = 1'b1;
    @(negedge clk) ppsStrobe = 1'b0;
  endtask

  task wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task wait_idle(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task csr_write(input logic [31:0] v);
    @(negedge clk);
    bus.csrStrobe = 1'b1;
    bus.GPIO_OUT  = v;
    @(negedge clk);
    bus.csrStrobe = 1'b0;
    bus.GPIO_OUT  = 32'h0;
  endtask

  task test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.status !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", bus.status); end
    checks++; if (alarm !== 2'b00) begin errors++; $display("FAIL reset_alarm: got %b expected 00", alarm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.selStrobe !== 1'b0) begin errors++; $display("FAIL reset_selStrobe: got %b expected 0", bus.selStrobe); end
    checks++; if (bus.selValue !== 32'h0) begin errors++; $display("FAIL reset_selValue: got %h expected 0", bus.selValue); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task test_scan_timing();
    int t;
    clear_logs();
    pulse_pps();
    t = pps_cyc;
    wait_idle(60);
    checks++; if (sel_log.size() !== 2) begin errors++; $display("FAIL timing_sel_count: got %0d expected 2", sel_log.size()); end
    checks++; if ((sel_log.size() > 0 ? sel_log[0] : -1) !== t + 17) begin errors++; $display("FAIL timing_sel0: got %0d expected %0d", (sel_log.size() > 0 ? sel_log[0] : -1), t + 17); end
    checks++; if ((sel_log.size() > 1 ? sel_log[1] : -1) !== t + 23) begin errors++; $display("FAIL timing_sel1: got %0d expected %0d", (sel_log.size() > 1 ? sel_log[1] : -1), t + 23); end
    checks++; if ((selv_log.size() > 1 ? selv_log[1] : -1) !== 1) begin errors++; $display("FAIL timing_selval1: got %0d expected 1", (selv_log.size() > 1 ? selv_log[1] : -1)); end
    checks++; if (busy_cnt !== 28) begin errors++; $display("FAIL timing_busy_cycles: got %0d expected 28", busy_cnt); end
    checks++; if (alarm !== 2'b00) begin errors++; $display("FAIL timing_alarm: got %b expected 00", alarm); end
    csr_write(32'h1);
    @(negedge clk);
    checks++; if (bus.status !== 32'hC7735940) begin errors++; $display("FAIL readback_ch1: got %h expected c7735940", bus.status); end
    csr_write(32'h0);
    @(negedge clk);
    checks++; if (bus.status !== 32'h85F5E100) begin errors++; $display("FAIL readback_ch0: got %h expected 85f5e100", bus.status); end
  endtask

  task test_alarm_sticky();
    ch_val0 = 32'd100_002_000;
    pulse_pps();
    wait_idle(60);
    checks++; if (alarm !== 2'b01) begin errors++; $display("FAIL alarm_set: got %b expected 01", alarm); end
    ch_val0 = 32'h05F5E100;
    pulse_pps();
    wait_idle(60);
    checks++; if (alarm !== 2'b01) begin errors++; $display("FAIL alarm_sticky: got %b expected 01", alarm); end
  endtask

  task test_clear_race();
    int t;
    ch_val0 = 32'd100_002_000;
    csr_write(32'h8000_0000);
    checks++; if (alarm !== 2'b00) begin errors++; $display("FAIL clear_idle_first: got %b expected 00", alarm); end
    clear_logs();
    pulse_pps();
    t = pps_cyc;
    wait_until(t + 21);
    checks++; if (dbg_state !== S_CAPTURE) begin errors++; $display("FAIL race_state: got %0d expected %0d", dbg_state, S_CAPTURE); end
    bus.csrStrobe = 1'b1;
    bus.GPIO_OUT  = 32'h8000_0000;
    @(negedge clk);
    bus.csrStrobe = 1'b0;
    bus.GPIO_OUT  = 32'h0;
    wait_idle(60);
    checks++; if (alarm !== 2'b01) begin errors++; $display("FAIL race_set_wins: got %b expected 01", alarm); end
    csr_write(32'h8000_0000);
    checks++; if (alarm !== 2'b00) begin errors++; $display("FAIL clear_idle: got %b expected 00", alarm); end
    @(negedge clk);
    checks++; if (bus.status !== 32'h85F5E8D0) begin errors++; $display("FAIL readback_high_ch0: got %h expected 85f5e8d0", bus.status); end
  endtask

  task test_disabled_channel();
    ch_val0 = 32'h05F5E100;
    ch_val1 = 32'h0;
    lowLimit[59:30]  = 30'd5;
    highLimit[59:30] = 30'd0;
    pulse_pps();
    wait_idle(60);
    checks++; if (alarm !== 2'b00) begin errors++; $display("FAIL disabled_ch1: got %b expected 00", alarm); end
    csr_write(32'h1);
    @(negedge clk);
    checks++; if (bus.status !== 32'h8000_0000) begin errors++; $display("FAIL readback_zero_ch1: got %h expected 80000000", bus.status); end
  endtask

  task test_back_to_back();
    int t;
    clear_logs();
    pulse_pps();
    t = pps_cyc;
    pps_at(t + 20);
    pps_at(t + 25);
    wait_idle(120);
    checks++; if (sel_log.size() !== 4) begin errors++; $display("FAIL b2b_sel_count: got %0d expected 4", sel_log.size()); end
    checks++; if ((sel_log.size() > 2 ? sel_log[2] : -1) !== t + 45) begin errors++; $display("FAIL b2b_sel2: got %0d expected %0d", (sel_log.size() > 2 ? sel_log[2] : -1), t + 45); end
    checks++; if ((sel_log.size() > 3 ? sel_log[3] : -1) !== t + 51) begin errors++; $display("FAIL b2b_sel3: got %0d expected %0d", (sel_log.size() > 3 ? sel_log[3] : -1), t + 51); end
    checks++; if (busy_cnt !== 56) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 56", busy_cnt); end
    repeat (40) @(negedge clk);
    checks++; if (sel_log.size() !== 4) begin errors++; $display("FAIL b2b_no_third_scan: got %0d expected 4", sel_log.size()); end
  endtask

  task test_reset_midscan();
    int t;
    ch_val0 = 32'd100_002_000;
    clear_logs();
    pulse_pps();
    t = pps_cyc;
    wait_until(t + 24);
    checks++; if (dbg_state !== S_SETTLE) begin errors++; $display("FAIL mid_state: got %0d expected %0d", dbg_state, S_SETTLE); end
    checks++; if (alarm !== 2'b01) begin errors++; $display("FAIL mid_alarm_before: got %b expected 01", alarm); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    checks++; if (alarm !== 2'b00) begin errors++; $display("FAIL mid_rst_alarm: got %b expected 00", alarm); end
    checks++; if (bus.status !== 32'h0) begin errors++; $display("FAIL mid_rst_status: got %h expected 0", bus.status); end
    checks++; if (bus.selValue !== 32'h0) begin errors++; $display("FAIL mid_rst_selValue: got %h expected 0", bus.selValue); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d expected %0d", dbg_state, S_IDLE); end
    @(negedge clk) rst_n = 1'b1;
    ch_val0 = 32'h05F5E100;
    repeat (2) @(negedge clk);
    checks++; if (bus.status !== 32'h0) begin errors++; $display("FAIL mid_valid_cleared: got %h expected 0", bus.status); end
    clear_logs();
    pulse_pps();
    t = pps_cyc;
    wait_idle(60);
    checks++; if ((sel_log.size() > 0 ? sel_log[0] : -1) !== t + 17) begin errors++; $display("FAIL post_rst_sel0: got %0d expected %0d", (sel_log.size() > 0 ? sel_log[0] : -1), t + 17); end
    checks++; if ((selv_log.size() > 0 ? selv_log[0] : -1) !== 0) begin errors++; $display("FAIL post_rst_first_ch: got %0d expected 0", (selv_log.size() > 0 ? selv_log[0] : -1)); end
    checks++; if (alarm !== 2'b00) begin errors++; $display("FAIL post_rst_alarm: got %b expected 00", alarm); end
    checks++; if (bus.status !== 32'h85F5E100) begin errors++; $display("FAIL post_rst_status: got %h expected 85f5e100", bus.status); end
  endtask

  initial begin
    bus.csrStrobe = 1'b0;
    bus.GPIO_OUT  = 32'h0;
    lowLimit  = {30'd0, 30'd99_999_000};
    highLimit = {30'd0, 30'd100_001_000};
    test_reset();
    test_scan_timing();
    test_alarm_sticky();
    test_clear_race();
    test_disabled_channel();
    test_back_to_back();
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
